// File: rtl/pc_pkg.sv
// Shared types and helpers for the Hack program counter with return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LOAD = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_cmd_t;

  localparam logic [63:0] PC_RESET_VALUE = 64'd0;

  // Fixed priority: load > call > ret > increment > hold.
  function automatic pc_cmd_t pc_decode(input logic load, input logic call,
                                        input logic ret, input logic increment);
    pc_cmd_t cmd;
    if (load) begin
      cmd = PC_LOAD;
    end else if (call) begin
      cmd = PC_CALL;
    end else if (ret) begin
      cmd = PC_RET;
    end else if (increment) begin
      cmd = PC_INC;
    end else begin
      cmd = PC_HOLD;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Register-based LIFO of return addresses; callers must not push when full or pop when empty.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    top_idx;

  assign top_idx = depth_q - DW'(1);
  assign top     = mem_q[top_idx[AW-1:0]];
  assign depth   = depth_q;
  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push && !full) begin
      mem_q[depth_q[AW-1:0]] <= push_data;
      depth_q                <= depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Hack CPU program counter with call/return stack and sticky fault flags.
// Optional breakpoint/halt logic is built when PC_BREAKPOINT_EN is defined.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_value,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic             increment,
`ifdef PC_BREAKPOINT_EN
  input  logic [WIDTH-1:0] bp_addr,
  input  logic             bp_arm,
  input  logic             resume,
`endif
  output logic [WIDTH-1:0] out,
  output logic [DW-1:0]    depth,
  output logic             stack_overflow,
  output logic             stack_underflow,
  output logic             halted
);

  logic [WIDTH-1:0] out_q, out_d, out_inc, stk_top;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop, stk_full, stk_empty;
  pc_cmd_t          cmd;

  assign out_inc = out_q + WIDTH'(1);

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (out_inc),
    .top       (stk_top),
    .depth     (depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

`ifdef PC_BREAKPOINT_EN
  logic halted_q, halted_d;
`endif

  always_comb begin
    cmd = pc_decode(load, call, ret, increment);
`ifdef PC_BREAKPOINT_EN
    if (halted_q && !resume) begin
      cmd = PC_HOLD;
    end
`endif
    out_d = out_q;
    push  = 1'b0;
    pop   = 1'b0;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case (cmd)
      PC_INC:  out_d = out_inc;
      PC_LOAD: out_d = in_value;
      PC_CALL: begin
        out_d = in_value;
        if (stk_full) begin
          ovf_d = 1'b1;
        end else begin
          push = 1'b1;
        end
      end
      PC_RET: begin
        if (stk_empty) begin
          unf_d = 1'b1;
        end else begin
          pop   = 1'b1;
          out_d = stk_top;
        end
      end
      default: ;
    endcase
  end

`ifdef PC_BREAKPOINT_EN
  // Only fire on arrival at bp_addr, so sitting on it after resume does not re-halt.
  always_comb begin
    halted_d = 1'b0;
    if (halted_q && !resume) begin
      halted_d = 1'b1;
    end else if (bp_arm && (out_d == bp_addr) && (out_q != bp_addr)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= PC_RESET_VALUE[WIDTH-1:0];
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign out             = out_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed self-checking bench for program_counter_stack (WIDTH=16, DEPTH=4).
module tb_program_counter_stack;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_value;
  logic             load, call, ret, increment;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             stack_overflow, stack_underflow, halted;
`ifdef PC_BREAKPOINT_EN
  logic [WIDTH-1:0] bp_addr;
  logic             bp_arm, resume;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  program_counter_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_value        (in_value),
    .load            (load),
    .call            (call),
    .ret             (ret),
    .increment       (increment),
`ifdef PC_BREAKPOINT_EN
    .bp_addr         (bp_addr),
    .bp_arm          (bp_arm),
    .resume          (resume),
`endif
    .out             (out),
    .depth           (depth),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow),
    .halted          (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic l, input logic c, input logic r, input logic i,
                     input logic [WIDTH-1:0] v);
    load = l; call = c; ret = r; increment = i; in_value = v;
    step();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; call = 1'b0; ret = 1'b0; increment = 1'b0; in_value = '0;
`ifdef PC_BREAKPOINT_EN
    bp_addr = '0; bp_arm = 1'b0; resume = 1'b0;
`endif
    #1;
    // Reset dominates a simultaneous load
    cmd(1, 0, 0, 0, 16'h1234);
    check("rst_out", 32'(out), 32'h0);
    check("rst_depth", 32'(depth), 32'h0);
    check("rst_ovf", 32'(stack_overflow), 32'h0);
    check("rst_unf", 32'(stack_underflow), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    reset = 1'b0;

    cmd(1, 0, 0, 0, 16'h0005);
    check("load5", 32'(out), 32'h5);
    repeat (3) cmd(0, 0, 0, 1, 16'h0);
    check("inc3", 32'(out), 32'h8);
    cmd(1, 0, 0, 1, 16'h0100);
    check("load_over_inc", 32'(out), 32'h100);
    check("load_depth", 32'(depth), 32'h0);
    cmd(0, 0, 0, 0, 16'h0);
    check("hold", 32'(out), 32'h100);

    cmd(1, 0, 0, 0, 16'h0010);
    cmd(0, 1, 0, 0, 16'h0200);
    check("call_out", 32'(out), 32'h200);
    check("call_depth", 32'(depth), 32'h1);
    repeat (2) cmd(0, 0, 0, 1, 16'h0);
    check("inc_in_sub", 32'(out), 32'h202);
    cmd(0, 0, 1, 0, 16'h0);
    check("ret_out", 32'(out), 32'h11);
    check("ret_depth", 32'(depth), 32'h0);

    // Fill the stack, then overflow
    cmd(1, 0, 0, 0, 16'h0000);
    cmd(0, 1, 0, 0, 16'h0100);
    cmd(0, 1, 0, 0, 16'h0200);
    cmd(0, 1, 0, 0, 16'h0300);
    cmd(0, 1, 0, 0, 16'h0400);
    check("full_depth", 32'(depth), 32'h4);
    check("no_ovf_yet", 32'(stack_overflow), 32'h0);
    cmd(0, 1, 0, 0, 16'h0500);
    check("ovf_out", 32'(out), 32'h500);
    check("ovf_depth", 32'(depth), 32'h4);
    check("ovf_flag", 32'(stack_overflow), 32'h1);
    cmd(0, 0, 1, 0, 16'h0);
    check("ret1", 32'(out), 32'h301);
    cmd(0, 0, 1, 0, 16'h0);
    check("ret2", 32'(out), 32'h201);
    cmd(0, 0, 1, 0, 16'h0);
    check("ret3", 32'(out), 32'h101);
    cmd(0, 0, 1, 0, 16'h0);
    check("ret4", 32'(out), 32'h1);
    check("ret4_depth", 32'(depth), 32'h0);

    // Underflow
    cmd(1, 0, 0, 0, 16'h0042);
    cmd(0, 0, 1, 0, 16'h0);
    check("unf_out", 32'(out), 32'h42);
    check("unf_flag", 32'(stack_underflow), 32'h1);
    repeat (2) cmd(0, 0, 0, 1, 16'h0);
    check("unf_sticky", 32'(stack_underflow), 32'h1);
    check("ovf_sticky", 32'(stack_overflow), 32'h1);

    // Wrap on increment and on pushed return address
    cmd(1, 0, 0, 0, 16'hFFFF);
    cmd(0, 0, 0, 1, 16'h0);
    check("inc_wrap", 32'(out), 32'h0);
    cmd(1, 0, 0, 0, 16'hFFFF);
    cmd(0, 1, 0, 0, 16'h0000);
    check("call_wrap_depth", 32'(depth), 32'h1);
    repeat (2) cmd(0, 0, 0, 1, 16'h0);
    cmd(0, 0, 1, 0, 16'h0);
    check("ret_wrap", 32'(out), 32'h0);

    // call beats ret, ret beats increment
    cmd(1, 0, 0, 0, 16'h0020);
    cmd(0, 1, 1, 1, 16'h0300);
    check("call_prio_out", 32'(out), 32'h300);
    check("call_prio_depth", 32'(depth), 32'h1);
    cmd(0, 0, 1, 1, 16'h0);
    check("ret_prio_out", 32'(out), 32'h21);
    check("ret_prio_depth", 32'(depth), 32'h0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_ovf", 32'(stack_overflow), 32'h0);
    check("rst2_unf", 32'(stack_underflow), 32'h0);

`ifdef PC_BREAKPOINT_EN
    bp_addr = 16'h0003; bp_arm = 1'b1;
    repeat (3) cmd(0, 0, 0, 1, 16'h0);
    check("bp_out", 32'(out), 32'h3);
    check("bp_halted", 32'(halted), 32'h1);
    repeat (2) cmd(0, 0, 0, 1, 16'h0);
    check("bp_hold", 32'(out), 32'h3);
    resume = 1'b1;
    cmd(0, 0, 0, 1, 16'h0);
    resume = 1'b0;
    check("bp_resume_out", 32'(out), 32'h4);
    check("bp_resume_halted", 32'(halted), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
